pipe_rca_adder: RTL



---
 rtl/pipe_rca_adder_pkg.sv | 26 ++
 rtl/pipe_rca_seg.sv | 65 ++++++
 rtl/pipe_rca_adder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_rca_adder_pkg.sv
// Shared definitions for the carry-pipelined ripple adder.
// Holds the default segment width, the stage-count helper and the
// elaboration-time width legality check used by pipe_rca_adder.
package pipe_rca_adder_pkg;

  // Default number of bits handled by one pipeline segment.
  localparam int DEFAULT_SEG = 32'sd4;

  // Number of segments (and therefore latency in cycles) for a given split.
  // A zero segment width is illegal; return 1 so elaboration reaches the
  // width check instead of dividing by zero.
  function automatic int calc_stages(input int width, input int seg);
    if (seg > 32'sd0) begin
      return width / seg;
    end else begin
      return 32'sd1;
    end
  endfunction

  // A split is legal when the segment width is positive, not wider than the
  // operand, and divides the operand width exactly.
  function automatic bit width_ok(input int width, input int seg);
    return (seg > 32'sd0) && (width >= seg) && ((width % seg) == 32'sd0);
  endfunction

endpackage

// File: rtl/pipe_rca_seg.sv
// One SEG-bit slice of the carry-pipelined ripple adder.
// Adds an already-aligned operand slice with the incoming carry and registers
// the slice sum and carry-out. Only the most significant segment (LAST=1)
// produces a signed overflow flag; every other segment drives ovf_o as 0 so
// the top level can simply OR-reduce the flags.
module pipe_rca_seg
  import pipe_rca_adder_pkg::*;
#(
  parameter int SEG  = DEFAULT_SEG,
  parameter bit LAST = 1'b0
) (
  input  logic           CK,
  input  logic           RST,
  input  logic           HOLD,
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           c_i,
  output logic [SEG-1:0] sum_o,
  output logic           c_o,
  output logic           ovf_o
);

  logic [SEG:0]   add_s;
  logic [SEG-1:0] sum_d;
  logic [SEG-1:0] sum_q;
  logic           c_d;
  logic           c_q;
  logic           ovf_d;
  logic           ovf_q;

  // Slice adder: sum, carry-out and (top slice only) signed overflow.
  // The carry into the MSB is recovered as a ^ b ^ sum at that bit.
  always_comb begin
    add_s = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, c_i};
    sum_d = add_s[SEG-1:0];
    c_d   = add_s[SEG];
    if (LAST) begin
      ovf_d = a_i[SEG-1] ^ b_i[SEG-1] ^ add_s[SEG-1] ^ add_s[SEG];
    end else begin
      ovf_d = 1'b0;
    end
  end

  // Result registers: cleared by reset, frozen while HOLD is high.
  always_ff @(posedge CK) begin
    if (RST) begin
      sum_q <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (!HOLD) begin
      sum_q <= sum_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end else begin
      sum_q <= sum_q;
      c_q   <= c_q;
      ovf_q <= ovf_q;
    end
  end

  assign sum_o = sum_q;
  assign c_o   = c_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_rca_adder.sv
// Carry-pipelined ripple adder.
// A WIDTH-bit add is split into STAGES = WIDTH/SEG segments with the carry
// registered between them. Operand slice k is delayed k cycles so it meets
// its carry, and slice sum k is delayed STAGES-1-k cycles so that every
// slice of one operation reaches SUM together. Latency is STAGES cycles of
// non-held clock edges, throughput one operation per cycle.
// Optional feature macro: PIPE_RCA_ADDER_SUB_EN adds a SUB input that turns
// the operation into A-B (CIN ignored, COUT=1 means no borrow).
module pipe_rca_adder
  import pipe_rca_adder_pkg::*;
#(
  parameter int WIDTH = 32'sd16,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             HOLD,
  input  logic             IN_VLD,
  input  logic             CIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef PIPE_RCA_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             OUT_VLD,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  if (!width_ok(WIDTH, SEG)) begin : g_bad_width
    $error("pipe_rca_adder: WIDTH must be a positive multiple of SEG");
  end

  // Operand B and carry-in as seen by the segment chain.
  logic [WIDTH-1:0] b_in_s;
  logic             cin_in_s;

`ifdef PIPE_RCA_ADDER_SUB_EN
  // Subtract is folded in before the skew registers: inverting B and forcing
  // carry-in here is the same as skewing SUB next to each slice, without the
  // extra per-stage flag registers.
  always_comb begin
    if (SUB) begin
      b_in_s   = ~B;
      cin_in_s = 1'b1;
    end else begin
      b_in_s   = B;
      cin_in_s = CIN;
    end
  end
`else
  // Add only: operands go straight into the pipeline.
  always_comb begin
    b_in_s   = B;
    cin_in_s = CIN;
  end
`endif

  // Per-segment aligned inputs and registered outputs.
  logic [SEG-1:0]    a_seg_s   [STAGES];
  logic [SEG-1:0]    b_seg_s   [STAGES];
  logic [SEG-1:0]    sum_seg_s [STAGES];
  logic [STAGES-1:0] cin_seg_s;
  logic [STAGES-1:0] cout_seg_s;
  logic [STAGES-1:0] ovf_seg_s;

  for (genvar k = 32'sd0; k < STAGES; k++) begin : g_stage

    localparam int DSK = STAGES - 32'sd1 - k;

    if (k == 32'sd0) begin : g_noskew
      assign a_seg_s[k]   = A[SEG-1:0];
      assign b_seg_s[k]   = b_in_s[SEG-1:0];
      assign cin_seg_s[k] = cin_in_s;
    end else begin : g_skew
      logic [SEG-1:0] a_skew_d [k];
      logic [SEG-1:0] a_skew_q [k];
      logic [SEG-1:0] b_skew_d [k];
      logic [SEG-1:0] b_skew_q [k];

      // Operand skew shift: slice k enters here and leaves k cycles later.
      always_comb begin
        a_skew_d[0] = A[k*SEG +: SEG];
        b_skew_d[0] = b_in_s[k*SEG +: SEG];
        for (int j = 32'sd1; j < k; j++) begin
          a_skew_d[j] = a_skew_q[j-1];
          b_skew_d[j] = b_skew_q[j-1];
        end
      end

      // Operand skew registers: cleared by reset, frozen while HOLD is high.
      always_ff @(posedge CK) begin
        if (RST) begin
          a_skew_q <= '{default: '0};
          b_skew_q <= '{default: '0};
        end else if (!HOLD) begin
          a_skew_q <= a_skew_d;
          b_skew_q <= b_skew_d;
        end else begin
          a_skew_q <= a_skew_q;
          b_skew_q <= b_skew_q;
        end
      end

      assign a_seg_s[k]   = a_skew_q[k-1];
      assign b_seg_s[k]   = b_skew_q[k-1];
      assign cin_seg_s[k] = cout_seg_s[k-1];
    end

    pipe_rca_seg #(
      .SEG  (SEG),
      .LAST (k == (STAGES - 32'sd1))
    ) u_seg (
      .CK    (CK),
      .RST   (RST),
      .HOLD  (HOLD),
      .a_i   (a_seg_s[k]),
      .b_i   (b_seg_s[k]),
      .c_i   (cin_seg_s[k]),
      .sum_o (sum_seg_s[k]),
      .c_o   (cout_seg_s[k]),
      .ovf_o (ovf_seg_s[k])
    );

    if (DSK == 32'sd0) begin : g_nodeskew
      assign SUM[k*SEG +: SEG] = sum_seg_s[k];
    end else begin : g_deskew
      logic [SEG-1:0] dsk_d [DSK];
      logic [SEG-1:0] dsk_q [DSK];

      // Result de-skew shift: lower slices wait for the upper slices.
      always_comb begin
        dsk_d[0] = sum_seg_s[k];
        for (int j = 32'sd1; j < DSK; j++) begin
          dsk_d[j] = dsk_q[j-1];
        end
      end

      // De-skew registers: cleared by reset, frozen while HOLD is high.
      always_ff @(posedge CK) begin
        if (RST) begin
          dsk_q <= '{default: '0};
        end else if (!HOLD) begin
          dsk_q <= dsk_d;
        end else begin
          dsk_q <= dsk_q;
        end
      end

      assign SUM[k*SEG +: SEG] = dsk_q[DSK-1];
    end
  end

  // Valid tag travels STAGES deep alongside the data.
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] vld_q;

  // Valid shift: new tag enters at bit 0.
  always_comb begin
    vld_d    = vld_q << 1'b1;
    vld_d[0] = IN_VLD;
  end

  // Valid registers: reset discards all in-flight operations.
  always_ff @(posedge CK) begin
    if (RST) begin
      vld_q <= '0;
    end else if (!HOLD) begin
      vld_q <= vld_d;
    end else begin
      vld_q <= vld_q;
    end
  end

  assign OUT_VLD = vld_q[STAGES-1];
  assign COUT    = cout_seg_s[STAGES-1];
  // Only the top segment can raise its overflow flag.
  assign OVF     = |ovf_seg_s;

endmodule
